ram_read_sequencer: RTL and testbench

Command-driven read address sequencer that sits directly upstream of the block-RAM read port. It turns one {base, length, stride} command into a stream of read addresses on the RAM's address/ready handshake, then tags the returned read data with a last-beat marker and a completion pulse. Typical use is replaying a stored frame out of block RAM into a downstream streaming consumer.

---
 rtl/ram_read_sequencer_pkg.sv | 14 +
 rtl/ram_read_sequencer_if.sv | 52 +++++
 rtl/ram_read_sequencer_addr_gen.sv | 66 ++++++
 rtl/ram_read_sequencer.sv | 108 ++++++++++
 tb/tb_ram_read_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_read_sequencer_pkg.sv
// Shared types for the block-RAM read sequencer: FSM state encoding and address-width helper.
package ram_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_read_sequencer_if.sv
// Bundle of command, RAM address/data and output stream signals for ram_read_sequencer.
// The master modport is the sequencer itself; slave is the surrounding RAM/command/consumer side.
interface ram_read_sequencer_if
  import ram_read_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
);
  localparam int AW = addr_width(DEPTH);

  logic [AW-1:0]    i_cmd_base;
  logic [AW:0]      i_cmd_len;
  logic [AW-1:0]    i_cmd_stride;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [AW-1:0]    o_rd_addr;
  logic             o_rd_addr_valid;
  logic             i_rd_addr_ready;
  logic [WIDTH-1:0] i_rd_data;
  logic             i_rd_valid;
  logic             o_rd_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             i_ready;
  logic             o_done;

  modport master (
    input  i_cmd_base, i_cmd_len, i_cmd_stride, i_cmd_valid,
    output o_cmd_ready,
    output o_rd_addr, o_rd_addr_valid,
    input  i_rd_addr_ready,
    input  i_rd_data, i_rd_valid,
    output o_rd_ready,
    output o_data, o_valid, o_last,
    input  i_ready,
    output o_done
  );

  modport slave (
    output i_cmd_base, i_cmd_len, i_cmd_stride, i_cmd_valid,
    input  o_cmd_ready,
    input  o_rd_addr, o_rd_addr_valid,
    output i_rd_addr_ready,
    output i_rd_data, i_rd_valid,
    input  o_rd_ready,
    input  o_data, o_valid, o_last,
    output i_ready,
    input  o_done
  );

endinterface

// File: rtl/ram_read_sequencer_addr_gen.sv
// Read-address generator: address register, mod-DEPTH stride step and remaining-issue counter.
// RAM_READ_SEQUENCER_STRIDE_EN selects a latched stride; otherwise the step is a fixed +1 with wrap.
module ram_read_sequencer_addr_gen
  import ram_read_sequencer_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] stride,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          last_issue
);

  logic [AW:0]   remaining;
  logic [AW-1:0] next_addr;

`ifdef RAM_READ_SEQUENCER_STRIDE_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] stride_q;
  logic [AW:0]   sum;
  logic [AW:0]   wrapped;

  // addr and stride are both below DEPTH, so one conditional subtract is a full modulo
  assign sum       = {1'b0, addr} + {1'b0, stride_q};
  assign wrapped   = (sum >= DEPTH_W) ? (sum - DEPTH_W) : sum;
  assign next_addr = wrapped[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
    end
  end
`else
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // stride input is ignored in the fixed-increment build
  logic unused_stride;
  assign unused_stride = ^stride;
  assign next_addr     = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (advance) begin
      addr      <= next_addr;
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign last_issue = (remaining == (AW+1)'(1));

endmodule

// File: rtl/ram_read_sequencer.sv
// Command-driven block-RAM read sequencer: issues {base,len,stride} addresses, tags returned beats with last/done.
// Optional build macro: RAM_READ_SEQUENCER_STRIDE_EN (honour i_cmd_stride; otherwise stride is 1).
module ram_read_sequencer
  import ram_read_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  ram_read_sequencer_if.master  bus
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   len_q;
  logic [AW:0]   beat_cnt;
  logic          cmd_ready_q;
  logic          addr_valid_q;
  logic          done_q;
  logic [AW-1:0] addr;
  logic          last_issue;

  logic active, cmd_fire, load, addr_fire, beat_fire, last_beat, final_fire;

  assign active     = (state != IDLE);
  assign cmd_fire   = (state == IDLE) && cmd_ready_q && bus.i_cmd_valid;
  assign load       = cmd_fire && (bus.i_cmd_len != '0);
  assign addr_fire  = addr_valid_q && bus.i_rd_addr_ready;
  assign beat_fire  = active && bus.i_rd_valid && bus.i_ready;
  assign last_beat  = active && bus.i_rd_valid && (beat_cnt == len_q - ONE);
  assign final_fire = (state == DRAIN) && last_beat && bus.i_ready;

  ram_read_sequencer_addr_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .clk        (i_clock),
    .rst_n      (i_reset),
    .load       (load),
    .base       (bus.i_cmd_base),
    .len        (bus.i_cmd_len),
    .stride     (bus.i_cmd_stride),
    .advance    (addr_fire),
    .addr       (addr),
    .last_issue (last_issue)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      cmd_ready_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= '0;
      beat_cnt     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            len_q    <= bus.i_cmd_len;
            beat_cnt <= '0;
            if (load) begin
              state        <= ISSUE;
              cmd_ready_q  <= 1'b0;
              addr_valid_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (beat_fire) beat_cnt <= beat_cnt + ONE;
          // RAM latency is at least one cycle, so completion is only ever seen from DRAIN
          if (addr_fire && last_issue) begin
            addr_valid_q <= 1'b0;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat_fire) beat_cnt <= beat_cnt + ONE;
          if (final_fire) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready     = cmd_ready_q;
  assign bus.o_rd_addr       = addr;
  assign bus.o_rd_addr_valid = addr_valid_q;
  assign bus.o_done          = done_q;

  // Return path is pure pass-through; in IDLE stray beats are swallowed once out of reset
  assign bus.o_valid    = active && bus.i_rd_valid;
  assign bus.o_data     = active ? bus.i_rd_data : {WIDTH{1'b0}};
  assign bus.o_last     = last_beat;
  assign bus.o_rd_ready = active ? bus.i_ready : cmd_ready_q;

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Randomized self-checking bench for ram_read_sequencer with a 1-cycle-latency RAM model.
// Expected addresses come from (base + i*stride) mod DEPTH; data from the bench's own memory image.
module tb_ram_read_sequencer;
  import ram_read_sequencer_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1000;
  localparam int AW    = addr_width(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_read_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_read_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q [$];
  int               got_addr [$];
  int               addr_cyc [$];
  logic [WIDTH-1:0] got_data [$];
  bit               got_last [$];
  int               beat_cyc [$];
  bit               tr_valid [$];
  bit               tr_ar [$];
  int               tr_addr [$];
  bit               tr_cready [$];
  int done_cnt, done_cyc, cyc;
  int ar_mode, dr_mode, rv_mode;

  function automatic int model_addr(input int base, input int stride, input int i);
    int s;
`ifdef RAM_READ_SEQUENCER_STRIDE_EN
    s = stride;
`else
    s = 1;
`endif
    return (base + i * s) % DEPTH;
  endfunction

  // mode 0: always high, 1: high on odd cycles, 2: random
  function automatic bit pick(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 1;
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic clear_logs();
    got_addr.delete(); addr_cyc.delete(); got_data.delete(); got_last.delete();
    beat_cyc.delete(); tr_valid.delete(); tr_ar.delete(); tr_addr.delete(); tr_cready.delete();
    done_cnt = 0; done_cyc = -1; cyc = 0;
  endtask

  task automatic step();
    bit ar, dr, rv;
    @(negedge clk);
    cyc++;
    bus.i_cmd_valid = 1'b0;
    ar = pick(ar_mode, cyc);
    dr = pick(dr_mode, cyc);
    rv = pick(rv_mode, cyc);
    bus.i_rd_addr_ready = ar;
    bus.i_ready         = dr;
    bus.i_rd_valid      = rv && (ram_q.size() > 0);
    if (ram_q.size() > 0) bus.i_rd_data = ram_q[0];
    else                  bus.i_rd_data = '0;
    #1;
    tr_valid.push_back(bus.o_rd_addr_valid);
    tr_ar.push_back(ar);
    tr_addr.push_back(int'(bus.o_rd_addr));
    tr_cready.push_back(bus.o_cmd_ready);
    if (bus.i_rd_valid && bus.o_rd_ready) void'(ram_q.pop_front());
    if (bus.o_valid && dr) begin
      got_data.push_back(bus.o_data);
      got_last.push_back(bus.o_last);
      beat_cyc.push_back(cyc);
    end
    if (bus.o_rd_addr_valid && ar) begin
      got_addr.push_back(int'(bus.o_rd_addr));
      addr_cyc.push_back(cyc);
      ram_q.push_back(mem[bus.o_rd_addr]);
    end
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic send_cmd(input int base, input int len, input int stride, output bit ok);
    ok = 1'b0;
    clear_logs();
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      bus.i_cmd_base      = AW'(base);
      bus.i_cmd_len       = (AW+1)'(len);
      bus.i_cmd_stride    = AW'(stride);
      bus.i_cmd_valid     = 1'b1;
      bus.i_rd_valid      = 1'b0;
      bus.i_rd_addr_ready = 1'b1;
      bus.i_ready         = 1'b1;
      #1;
      ok = bus.o_cmd_ready;
    end
  endtask

  task automatic run(input int budget, output bit timed_out);
    while (done_cnt == 0 && cyc < budget) step();
    step();
    step();
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_len = 11'd4; bus.i_cmd_base = '0; bus.i_cmd_stride = 10'd1;
    bus.i_rd_valid = 1'b1; bus.i_ready = 1'b1; bus.i_rd_addr_ready = 1'b1; bus.i_rd_data = 8'hA5;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.o_cmd_ready, bus.o_rd_addr_valid, bus.o_valid, bus.o_last, bus.o_done, bus.o_rd_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000 (cmd_ready,addr_valid,valid,last,done,rd_ready)",
               {bus.o_cmd_ready, bus.o_rd_addr_valid, bus.o_valid, bus.o_last, bus.o_done, bus.o_rd_ready});
    end
    total++;
    if (bus.o_rd_addr !== '0) begin
      bad++; $display("FAIL reset_addr: got %0d want 0", bus.o_rd_addr);
    end
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_rd_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: cmd_ready=%b rd_ready=%b valid=%b want 1 1 0",
               bus.o_cmd_ready, bus.o_rd_ready, bus.o_valid);
    end
    bus.i_rd_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit ok, to;
    ar_mode = 0; dr_mode = 0; rv_mode = 0;
    send_cmd(0, 4, 1, ok);
    run(60, to);
    total++;
    if (!ok || to) begin bad++; $display("FAIL basic_complete: accepted=%b timed_out=%b want 1 0", ok, to); end
    total++;
    if (got_addr.size() != 4) begin bad++; $display("FAIL basic_addr_count: got %0d want 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      total++;
      if (got_addr[i] != i || addr_cyc[i] != i + 1) begin
        bad++;
        $display("FAIL basic_addr[%0d]: got addr %0d at cycle %0d want addr %0d at cycle %0d", i, got_addr[i], addr_cyc[i], i, i + 1);
      end
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== mem[i] || got_last[i] != (i == 3)) begin
        bad++;
        $display("FAIL basic_beat[%0d]: got data %0h last %0b want %0h %0b", i, got_data[i], got_last[i], mem[i], i == 3);
      end
    end
    total++;
    if (done_cnt != 1 || beat_cyc.size() != 4 || done_cyc != beat_cyc[beat_cyc.size()-1] + 1) begin
      bad++;
      $display("FAIL basic_done: got %0d pulses at cycle %0d, beats %0d; want 1 pulse one cycle after beat 4", done_cnt, done_cyc, beat_cyc.size());
    end
    total++;
    if (tr_cready.size() <= done_cyc || done_cyc < 1 || tr_cready[done_cyc-1] !== 1'b1) begin
      bad++; $display("FAIL basic_ready_after: cmd_ready not 1 at done cycle %0d", done_cyc);
    end
  endtask

  task automatic test_wrap_stride();
    int tbl [3][3] = '{'{998, 4, 1}, '{5, 3, 300}, '{990, 5, 7}};
    bit ok, to;
    ar_mode = 0; dr_mode = 0; rv_mode = 0;
    for (int t = 0; t < 3; t++) begin
      send_cmd(tbl[t][0], tbl[t][1], tbl[t][2], ok);
      run(60, to);
      total++;
      if (!ok || to || got_addr.size() != tbl[t][1] || got_data.size() != tbl[t][1] || done_cnt != 1) begin
        bad++;
        $display("FAIL ws%0d_counts: accepted=%b timeout=%b addrs=%0d beats=%0d done=%0d want 1 0 %0d %0d 1",
                 t, ok, to, got_addr.size(), got_data.size(), done_cnt, tbl[t][1], tbl[t][1]);
      end
      for (int i = 0; i < got_addr.size() && i < tbl[t][1]; i++) begin
        total++;
        if (got_addr[i] != model_addr(tbl[t][0], tbl[t][2], i)) begin
          bad++;
          $display("FAIL ws%0d_addr[%0d]: got %0d want %0d", t, i, got_addr[i], model_addr(tbl[t][0], tbl[t][2], i));
        end
      end
      for (int i = 0; i < got_data.size() && i < tbl[t][1]; i++) begin
        total++;
        if (got_data[i] !== mem[model_addr(tbl[t][0], tbl[t][2], i)] || got_last[i] != (i == tbl[t][1] - 1)) begin
          bad++;
          $display("FAIL ws%0d_beat[%0d]: got %0h/%0b want %0h/%0b", t, i, got_data[i], got_last[i],
                   mem[model_addr(tbl[t][0], tbl[t][2], i)], i == tbl[t][1] - 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok, to;
    int stalls;
    ar_mode = 1; dr_mode = 2; rv_mode = 2;
    send_cmd(20, 6, 3, ok);
    run(200, to);
    total++;
    if (!ok || to || got_addr.size() != 6 || got_data.size() != 6 || done_cnt != 1) begin
      bad++;
      $display("FAIL stall_counts: accepted=%b timeout=%b addrs=%0d beats=%0d done=%0d want 1 0 6 6 1",
               ok, to, got_addr.size(), got_data.size(), done_cnt);
    end
    for (int i = 0; i < got_addr.size() && i < 6; i++) begin
      total++;
      if (got_addr[i] != model_addr(20, 3, i) || got_data.size() <= i || got_data[i] !== mem[model_addr(20, 3, i)]) begin
        bad++; $display("FAIL stall_addr[%0d]: got addr %0d want %0d", i, got_addr[i], model_addr(20, 3, i));
      end
    end
    stalls = 0;
    for (int k = 0; k + 1 < tr_valid.size(); k++) begin
      if (tr_valid[k] && !tr_ar[k]) begin
        stalls++;
        total++;
        if (!tr_valid[k+1] || tr_addr[k+1] != tr_addr[k]) begin
          bad++;
          $display("FAIL stall_hold cyc%0d: next valid=%b addr=%0d want 1 %0d", k + 1, tr_valid[k+1], tr_addr[k+1], tr_addr[k]);
        end
      end
    end
    total++;
    if (stalls < 5) begin bad++; $display("FAIL stall_seen: got %0d stalled cycles want >=5", stalls); end
  endtask

  task automatic test_len0();
    bit ok;
    int nvalid, nready;
    ar_mode = 0; dr_mode = 0; rv_mode = 0;
    send_cmd(7, 0, 3, ok);
    repeat (3) step();
    nvalid = 0; nready = 0;
    foreach (tr_valid[k]) begin
      nvalid += int'(tr_valid[k]);
      nready += int'(tr_cready[k]);
    end
    total++;
    if (!ok || nvalid != 0 || nready != 3) begin
      bad++; $display("FAIL len0_idle: accepted=%b addr_valid_cycles=%0d ready_cycles=%0d want 1 0 3", ok, nvalid, nready);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 1) begin
      bad++; $display("FAIL len0_done: got %0d pulses at cycle %0d want 1 at cycle 1", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, to;
    int nvalid;
    ar_mode = 0; dr_mode = 0; rv_mode = 0;
    send_cmd(100, 8, 1, ok);
    repeat (3) step();
    total++;
    if (!ok || got_addr.size() != 3) begin
      bad++; $display("FAIL rmid_pre: accepted=%b addrs=%0d want 1 3", ok, got_addr.size());
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_rd_valid = 1'b1; bus.i_ready = 1'b1; bus.i_rd_data = 8'h3C;
    #1;
    total++;
    if ({bus.o_cmd_ready, bus.o_rd_addr_valid, bus.o_valid, bus.o_last, bus.o_done, bus.o_rd_ready} !== 6'b0
        || bus.o_rd_addr !== '0 || bus.o_data !== '0) begin
      bad++;
      $display("FAIL rmid_async: ctrl=%b addr=%0d data=%0h want all zero",
               {bus.o_cmd_ready, bus.o_rd_addr_valid, bus.o_valid, bus.o_last, bus.o_done, bus.o_rd_ready},
               bus.o_rd_addr, bus.o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_rd_valid = 1'b0;
    ram_q.delete();
    done_cnt = 0;
    tr_valid.delete();
    repeat (4) step();
    nvalid = 0;
    foreach (tr_valid[k]) nvalid += int'(tr_valid[k]);
    total++;
    if (done_cnt != 0 || nvalid != 0) begin
      bad++; $display("FAIL rmid_abandon: done=%0d addr_valid_cycles=%0d want 0 0", done_cnt, nvalid);
    end
    send_cmd(10, 2, 1, ok);
    run(60, to);
    total++;
    if (!ok || to || got_addr.size() != 2 || done_cnt != 1) begin
      bad++; $display("FAIL rmid_next_counts: accepted=%b timeout=%b addrs=%0d done=%0d want 1 0 2 1", ok, to, got_addr.size(), done_cnt);
    end else begin
      total++;
      if (got_addr[0] != 10 || got_addr[1] != 11 || got_data.size() != 2 || got_data[1] !== mem[11] || !got_last[1]) begin
        bad++; $display("FAIL rmid_next_addr: got %0d,%0d want 10,11 with matching data and last", got_addr[0], got_addr[1]);
      end
    end
  endtask

  task automatic test_random();
    bit ok, to;
    int base, len, stride, errs;
    for (int n = 0; n < 25; n++) begin
      base = $urandom_range(0, DEPTH - 1);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(25, 60) : $urandom_range(1, 24);
      stride = $urandom_range(0, DEPTH - 1);
      ar_mode = $urandom_range(0, 2); dr_mode = $urandom_range(0, 2); rv_mode = $urandom_range(0, 2);
      send_cmd(base, len, stride, ok);
      run(2000, to);
      total++;
      if (!ok || to || got_addr.size() != len || got_data.size() != len || done_cnt != 1) begin
        bad++;
        $display("FAIL rnd%0d_counts: accepted=%b timeout=%b addrs=%0d beats=%0d done=%0d want 1 0 %0d %0d 1",
                 n, ok, to, got_addr.size(), got_data.size(), done_cnt, len, len);
        continue;
      end
      errs = 0;
      for (int i = 0; i < len; i++) begin
        if (got_addr[i] != model_addr(base, stride, i) || got_data[i] !== mem[model_addr(base, stride, i)]
            || got_last[i] != (i == len - 1)) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++; $display("FAIL rnd%0d_stream: %0d bad beats want 0 (base=%0d len=%0d stride=%0d)", n, errs, base, len, stride);
      end
      total++;
      if (done_cyc != beat_cyc[len-1] + 1) begin
        bad++; $display("FAIL rnd%0d_done_timing: done at %0d want %0d", n, done_cyc, beat_cyc[len-1] + 1);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    bus.i_cmd_base = '0; bus.i_cmd_len = '0; bus.i_cmd_stride = '0; bus.i_cmd_valid = 1'b0;
    bus.i_rd_addr_ready = 1'b0; bus.i_rd_data = '0; bus.i_rd_valid = 1'b0; bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap_stride();
    test_stall();
    test_len0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
